// File: rtl/add11_arbiter.sv
// add11_arbiter: 4-requester round-robin arbiter sharing one 11-bit ripple-carry adder
//   Optional feature macro: ADD11_ARB_CNT_EN adds the 8-bit txn_count output.
//   Ports:
//     clk, reset           clock and synchronous active-high reset
//     req[3:0]             per-requester addition request
//     a0..a3, b0..b3       11-bit operands of requesters 0..3
//     grant[3:0]           one-hot owner of the adder, zero when idle
//     ack[3:0]             one-hot one-cycle pulse alongside result_valid
//     result[11:0]         registered sum, bit 11 is the carry out
//     result_id[1:0]       requester that owns result
//     result_valid         one-cycle pulse when result is fresh
//     busy                 high whenever a transaction is in flight
//     txn_count[7:0]       completed transactions, wraps (macro only)
module add11_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [10:0] a0,
  input  logic [10:0] a1,
  input  logic [10:0] a2,
  input  logic [10:0] a3,
  input  logic [10:0] b0,
  input  logic [10:0] b1,
  input  logic [10:0] b2,
  input  logic [10:0] b3,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic [11:0] result,
  output logic [1:0]  result_id,
  output logic        result_valid,
  output logic        busy
`ifdef ADD11_ARB_CNT_EN
  ,
  output logic [7:0]  txn_count
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_ptr, r_win, w_win, r_id;
  logic [3:0]  r_grant, r_ack;
  logic [10:0] r_a, r_b, w_a, w_b, w_s;
  logic [11:0] r_result, w_c;
  logic        r_valid;
  always_comb begin
    w_win = r_ptr;
    for (int k = 3; k >= 0; k--)
      if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
  end
  assign w_a = w_win == 2'd0 ? a0 : w_win == 2'd1 ? a1 : w_win == 2'd2 ? a2 : a3;
  assign w_b = w_win == 2'd0 ? b0 : w_win == 2'd1 ? b1 : w_win == 2'd2 ? b2 : b3;
  assign w_c[0] = 1'b0;
  for (genvar g = 0; g < 11; g++) begin : g_fa
    assign w_s[g]   = r_a[g] ^ r_b[g] ^ w_c[g];
    assign w_c[g+1] = (r_a[g] & r_b[g]) | (w_c[g] & (r_a[g] ^ r_b[g]));
  end
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE ? (|req ? CALC : IDLE) : r_state == CALC ? RESP : IDLE;
  end
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_win    <= '0;
      r_id     <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      if (r_state == IDLE && |req) begin
        r_grant <= 4'b0001 << w_win;
        r_win   <= w_win;
        r_a     <= w_a;
        r_b     <= w_b;
        r_ptr   <= w_win + 2'd1;
      end
      if (r_state == CALC) begin
        r_result <= {w_c[11], w_s};
        r_id     <= r_win;
        r_valid  <= 1'b1;
        r_ack    <= r_grant;
      end
      if (r_state == RESP) r_grant <= '0;
    end
  end
`ifdef ADD11_ARB_CNT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge clk) r_cnt <= reset ? 8'd0 : r_cnt + 8'(r_state == CALC);
  assign txn_count = r_cnt;
`endif
  assign grant        = r_grant;
  assign ack          = r_ack;
  assign result       = r_result;
  assign result_id    = r_id;
  assign result_valid = r_valid;
  assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_add11_arbiter.sv
// tb_add11_arbiter: randomized self-checking bench with a round-robin reference model
module tb_add11_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [10:0] a [4];
  logic [10:0] b [4];
  logic [3:0]  grant, ack;
  logic [11:0] result;
  logic [1:0]  result_id;
  logic        result_valid, busy;
  int          total = 0;
  int          bad = 0;
  int          p = 0;
  int          cnt = 0;
`ifdef ADD11_ARB_CNT_EN
  logic [7:0]  txn_count;
`endif
  add11_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
    .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
    .grant(grant), .ack(ack), .result(result), .result_id(result_id),
    .result_valid(result_valid), .busy(busy)
`ifdef ADD11_ARB_CNT_EN
    , .txn_count(txn_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      a[i] = 11'($urandom);
      b[i] = 11'($urandom);
    end
    req = 4'($urandom);
  endtask
  task automatic txn(input logic [3:0] rq);
    int w;
    logic [11:0] s;
    req = rq;
    w = 0;
    for (int k = 3; k >= 0; k--) if (rq[(p + k) % 4]) w = (p + k) % 4;
    s = {1'b0, a[w]} + {1'b0, b[w]};
    @(posedge clk); #1;
    chk("grant", 32'(grant), 32'(1 << w));
    chk("busy_calc", 32'(busy), 1);
    chk("ack_early", 32'(ack), 0);
    chk("valid_early", 32'(result_valid), 0);
    scramble();
    @(posedge clk); #1;
    chk("result", 32'(result), 32'(s));
    chk("result_id", 32'(result_id), 32'(w));
    chk("ack", 32'(ack), 32'(1 << w));
    chk("valid", 32'(result_valid), 1);
    chk("grant_resp", 32'(grant), 32'(1 << w));
    scramble();
    @(posedge clk); #1;
    chk("grant_idle", 32'(grant), 0);
    chk("ack_idle", 32'(ack), 0);
    chk("valid_idle", 32'(result_valid), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("result_hold", 32'(result), 32'(s));
    chk("id_hold", 32'(result_id), 32'(w));
    p = (w + 1) % 4;
    cnt++;
  endtask
  initial begin
    reset = 1'b1;
    req = 4'd0;
    for (int i = 0; i < 4; i++) begin
      a[i] = 11'd0;
      b[i] = 11'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_id", 32'(result_id), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_grant", 32'(grant), 0);
    chk("idle_busy", 32'(busy), 0);
    a[0] = 11'd5;
    b[0] = 11'd7;
    txn(4'b0001);
    chk("sum_5_7", 32'(result), 12);
    a[2] = 11'd2047;
    b[2] = 11'd2047;
    txn(4'b0100);
    chk("carry_max", 32'(result), 32'h0FFE);
    req = 4'b0010;
    @(posedge clk); #1;
    chk("abort_grant", 32'(grant), 32'b0010);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req = 4'b0000;
    chk("abort_ack", 32'(ack), 0);
    chk("abort_valid", 32'(result_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_grant_clr", 32'(grant), 0);
    p = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) txn(4'b1111);
    for (int i = 0; i < 40; i++) begin
      scramble();
      txn(4'($urandom_range(1, 15)));
    end
`ifdef ADD11_ARB_CNT_EN
    while (cnt < 257) begin
      scramble();
      txn(4'($urandom_range(1, 15)));
    end
    chk("txn_count", 32'(txn_count), 32'(cnt % 256));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
